// File: rtl/cam_pkg.sv
// Shared state encodings, default OV7670 timing constants and per-state output decode.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PWDN      = 3'd1,
        ST_RESET     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CONFIG    = 3'd4,
        ST_READY     = 3'd5
    } seq_state_t;

    localparam int CAM_REFCLK_HZ       = 12_000_000;
    localparam int CAM_LOCK_FILTER_CYC = 16;
    localparam int CAM_PWDN_CYC        = CAM_REFCLK_HZ / 1000;
    localparam int CAM_RESET_CYC       = CAM_REFCLK_HZ / 1000;
    localparam int CAM_SETTLE_CYC      = CAM_REFCLK_HZ / 1000;
    localparam int CAM_CFG_TIMEOUT_CYC = CAM_REFCLK_HZ / 10;

    typedef struct packed {
        logic pwdn;
        logic reset_n;
        logic xclk_en;
        logic cfg_start;
        logic ready;
    } cam_outs_t;

    function automatic int cam_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Output values held while in a state; cfg_start is only the entry-cycle value.
    function automatic cam_outs_t cam_outs(input seq_state_t s);
        cam_outs_t o;
        o = '{pwdn: 1'b1, reset_n: 1'b0, xclk_en: 1'b0, cfg_start: 1'b0, ready: 1'b0};
        case (s)
            ST_PWDN:   o.xclk_en = 1'b1;
            ST_RESET:  o = '{pwdn: 1'b0, reset_n: 1'b0, xclk_en: 1'b1, cfg_start: 1'b0, ready: 1'b0};
            ST_SETTLE: o = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1, cfg_start: 1'b0, ready: 1'b0};
            ST_CONFIG: o = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1, cfg_start: 1'b1, ready: 1'b0};
            ST_READY:  o = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1, cfg_start: 1'b0, ready: 1'b1};
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cam_power_sequencer_if.sv
// Sequencer bundle: lock/restart/config-done in, camera control and status out.
interface cam_power_sequencer_if;

    logic       pll_locked;
    logic       restart;
    logic       cfg_done;
    logic       cam_pwdn;
    logic       cam_reset_n;
    logic       xclk_en;
    logic       cfg_start;
    logic       cam_ready;
    logic       cfg_err;
    logic [2:0] seq_state;

    modport master (
        input  pll_locked, restart, cfg_done,
        output cam_pwdn, cam_reset_n, xclk_en, cfg_start, cam_ready, cfg_err, seq_state
    );

    modport slave (
        output pll_locked, restart, cfg_done,
        input  cam_pwdn, cam_reset_n, xclk_en, cfg_start, cam_ready, cfg_err, seq_state
    );

endinterface

// File: rtl/cam_lock_filter.sv
// Two-flop synchronizer plus consecutive-high filter on the PLL lock flag.
// lock_ok is high on the cycle the FILTER_CYCLES-th consecutive synced-high sample is present; drops with any low sample.
module cam_lock_filter
    import cam_pkg::*;
#(
    parameter int FILTER_CYCLES = CAM_LOCK_FILTER_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [FW-1:0] cnt;

    // cnt holds how many earlier consecutive high samples were seen, capped one short of the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= pll_locked;
            sync_q2 <= sync_q1;
            if (!sync_q2) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + FW'(1);
            end
        end
    end

    assign lock_ok = sync_q2 && (cnt == CNT_LAST);

endmodule

// File: rtl/cam_power_sequencer.sv
// OV7670 power-up/reset sequencer: lock qualify, PWDN, RESET, SETTLE, SCCB config, READY; outputs registered.
// No flow control; CAM_CFG_TIMEOUT_EN adds the sticky cfg_err configurator timeout with retry from PWDN.
module cam_power_sequencer
    import cam_pkg::*;
#(
    parameter int LOCK_FILTER_CYCLES = CAM_LOCK_FILTER_CYC,
    parameter int PWDN_CYCLES        = CAM_PWDN_CYC,
    parameter int RESET_CYCLES       = CAM_RESET_CYC,
    parameter int SETTLE_CYCLES      = CAM_SETTLE_CYC,
    parameter int CFG_TIMEOUT_CYCLES = CAM_CFG_TIMEOUT_CYC
) (
    input  logic                  refclk,
    input  logic                  rst,
    cam_power_sequencer_if.master seq_if
);

    localparam int MAX_CYC = cam_max(cam_max(PWDN_CYCLES, RESET_CYCLES),
                                     cam_max(SETTLE_CYCLES, CFG_TIMEOUT_CYCLES));
    localparam int CW = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] CNT_SAT     = '1;
    localparam logic [CW-1:0] PWDN_LAST   = CW'(PWDN_CYCLES - 1);
    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef CAM_CFG_TIMEOUT_EN
    localparam logic [CW-1:0] CFG_LAST    = CW'(CFG_TIMEOUT_CYCLES - 1);
`endif

    seq_state_t    state;
    logic [CW-1:0] cnt;
    cam_outs_t     outs;
    logic          lock_ok;
`ifdef CAM_CFG_TIMEOUT_EN
    logic          cfg_err_q;
`endif

    cam_lock_filter #(
        .FILTER_CYCLES (LOCK_FILTER_CYCLES)
    ) u_lock_filter (
        .clk        (refclk),
        .rst        (rst),
        .pll_locked (seq_if.pll_locked),
        .lock_ok    (lock_ok)
    );

    // cnt counts completed cycles in the current state; a state of N cycles exits when cnt == N-1.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
            outs  <= cam_outs(ST_WAIT_LOCK);
`ifdef CAM_CFG_TIMEOUT_EN
            cfg_err_q <= 1'b0;
`endif
        end else if (state != ST_WAIT_LOCK && !lock_ok) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
            outs  <= cam_outs(ST_WAIT_LOCK);
        end else if (state != ST_WAIT_LOCK && seq_if.restart) begin
            state <= ST_PWDN;
            cnt   <= '0;
            outs  <= cam_outs(ST_PWDN);
        end else begin
            if (cnt != CNT_SAT) begin
                cnt <= cnt + CW'(1);
            end
            outs.cfg_start <= 1'b0;
            case (state)
                ST_WAIT_LOCK: if (lock_ok) begin
                    state <= ST_PWDN;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_PWDN);
                end
                ST_PWDN: if (cnt == PWDN_LAST) begin
                    state <= ST_RESET;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_RESET);
                end
                ST_RESET: if (cnt == RESET_LAST) begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_SETTLE);
                end
                ST_SETTLE: if (cnt == SETTLE_LAST) begin
                    state <= ST_CONFIG;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_CONFIG);
                end
                ST_CONFIG: if (seq_if.cfg_done) begin
                    state <= ST_READY;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_READY);
                end
`ifdef CAM_CFG_TIMEOUT_EN
                else if (cnt == CFG_LAST) begin
                    cfg_err_q <= 1'b1;
                    state     <= ST_PWDN;
                    cnt       <= '0;
                    outs      <= cam_outs(ST_PWDN);
                end
`endif
                ST_READY: ;
                default: begin
                    state <= ST_WAIT_LOCK;
                    cnt   <= '0;
                    outs  <= cam_outs(ST_WAIT_LOCK);
                end
            endcase
        end
    end

    assign seq_if.cam_pwdn    = outs.pwdn;
    assign seq_if.cam_reset_n = outs.reset_n;
    assign seq_if.xclk_en     = outs.xclk_en;
    assign seq_if.cfg_start   = outs.cfg_start;
    assign seq_if.cam_ready   = outs.ready;
    assign seq_if.seq_state   = state;
`ifdef CAM_CFG_TIMEOUT_EN
    assign seq_if.cfg_err     = cfg_err_q;
`else
    assign seq_if.cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cam_power_sequencer.sv
// Bench for cam_power_sequencer with short timing parameters; vectors are {inputs, cycles, expected outputs}.
module tb_cam_power_sequencer;

    localparam int LF = 4;
    localparam int PW = 10;
    localparam int RS = 8;
    localparam int ST = 12;
    localparam int TO = 50;

    localparam logic [2:0] W = 3'd0;
    localparam logic [2:0] P = 3'd1;
    localparam logic [2:0] R = 3'd2;
    localparam logic [2:0] S = 3'd3;
    localparam logic [2:0] C = 3'd4;
    localparam logic [2:0] Y = 3'd5;

    typedef struct {
        logic       locked;
        logic       restart;
        logic       done;
        int         cyc;
        logic [2:0] st;
        logic       pwdn;
        logic       rstn;
        logic       xclk;
        logic       start;
        logic       ready;
        logic       err;
    } vec_t;

    logic  refclk = 1'b0;
    logic  rst    = 1'b1;
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";
    vec_t  exp_q[$];

    initial forever #5 refclk = ~refclk;

    cam_power_sequencer_if sif ();

    cam_power_sequencer #(
        .LOCK_FILTER_CYCLES (LF),
        .PWDN_CYCLES        (PW),
        .RESET_CYCLES       (RS),
        .SETTLE_CYCLES      (ST),
        .CFG_TIMEOUT_CYCLES (TO)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .seq_if (sif)
    );

    function automatic vec_t mk(input logic locked, input logic restart, input logic done, input int cyc,
                                input logic [2:0] st, input logic pwdn, input logic rstn, input logic xclk,
                                input logic start, input logic ready, input logic err);
        vec_t v;
        v.locked = locked; v.restart = restart; v.done = done; v.cyc = cyc;
        v.st = st; v.pwdn = pwdn; v.rstn = rstn; v.xclk = xclk;
        v.start = start; v.ready = ready; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic compare_head();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected a pending record", phase);
            return;
        end
        e = exp_q.pop_front();
        chk("seq_state",   sif.seq_state,       e.st);
        chk("cam_pwdn",    3'(sif.cam_pwdn),    3'(e.pwdn));
        chk("cam_reset_n", 3'(sif.cam_reset_n), 3'(e.rstn));
        chk("xclk_en",     3'(sif.xclk_en),     3'(e.xclk));
        chk("cfg_start",   3'(sif.cfg_start),   3'(e.start));
        chk("cam_ready",   3'(sif.cam_ready),   3'(e.ready));
        chk("cfg_err",     3'(sif.cfg_err),     3'(e.err));
    endtask

    // Called at a falling edge; restart/cfg_done are single-cycle pulses, pll_locked is held.
    task automatic apply(input vec_t v);
        sif.pll_locked = v.locked;
        sif.restart    = v.restart;
        sif.cfg_done   = v.done;
        exp_q.push_back(v);
        @(posedge refclk);
        #1;
        sif.restart  = 1'b0;
        sif.cfg_done = 1'b0;
        repeat (v.cyc - 1) @(posedge refclk);
        @(negedge refclk);
        compare_head();
    endtask

    // Datasheet ordering checks on every cycle.
    initial begin
        logic prev_rstn;
        logic prev_pwdn;
        int   xclk_run;
        prev_rstn = 1'b0;
        prev_pwdn = 1'b1;
        xclk_run  = 0;
        forever begin
            @(negedge refclk);
            if (!rst && sif.cam_reset_n && !prev_rstn) begin
                checks++;
                if (sif.cam_pwdn !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_n_rise_while_pwdn: got cam_pwdn=%0b expected 0 at %0t", sif.cam_pwdn, $time);
                end
            end
            if (!rst && prev_pwdn && !sif.cam_pwdn) begin
                checks++;
                if (xclk_run < PW) begin
                    errors++;
                    $display("FAIL xclk_before_pwdn_fall: got %0d cycles expected >= %0d at %0t", xclk_run, PW, $time);
                end
            end
            xclk_run  = (sif.xclk_en === 1'b1) ? xclk_run + 1 : 0;
            prev_rstn = sif.cam_reset_n;
            prev_pwdn = sif.cam_pwdn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        sif.pll_locked = 1'b0;
        sif.restart    = 1'b0;
        sif.cfg_done   = 1'b0;

        // Bring-up table: lock held high from reset through READY, lock drop, re-lock, rerun.
        phase = "reset";
        @(negedge refclk);
        apply(mk(1,0,0, 2, W,1,0,0,0,0,0));
        rst = 1'b0;
        tbl.push_back(mk(1,0,0, 5, W,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 1, P,1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 9, P,1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 1, R,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 7, R,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 1, S,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,0,11, S,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,0, 1, C,0,1,1,1,0,0));
        tbl.push_back(mk(1,0,0, 1, C,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,0, 4, C,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,1, 1, Y,0,1,1,0,1,0));
        tbl.push_back(mk(1,0,1,20, Y,0,1,1,0,1,0));
        tbl.push_back(mk(0,0,0, 2, Y,0,1,1,0,1,0));
        tbl.push_back(mk(0,0,0, 1, W,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 5, W,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 1, P,1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,10, R,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 8, S,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,0,12, C,0,1,1,1,0,0));
        tbl.push_back(mk(1,0,1, 1, Y,0,1,1,0,1,0));
        for (int i = 0; i < tbl.size(); i++) begin
            phase = $sformatf("table[%0d]", i);
            apply(tbl[i]);
        end

        // Glitchy lock: 3 high, 1 low (with an ignored restart), then 4 clean samples needed.
        phase = "glitch";
        rst = 1'b1;
        apply(mk(0,0,0, 2, W,1,0,0,0,0,0));
        rst = 1'b0;
        apply(mk(1,0,0, 3, W,1,0,0,0,0,0));
        apply(mk(0,1,0, 1, W,1,0,0,0,0,0));
        apply(mk(1,0,0, 5, W,1,0,0,0,0,0));
        apply(mk(1,0,0, 1, P,1,0,1,0,0,0));

        // restart in RESET at count 3, then restart coinciding with cfg_done in CONFIG.
        phase = "restart";
        apply(mk(1,0,0,10, R,0,0,1,0,0,0));
        apply(mk(1,0,0, 3, R,0,0,1,0,0,0));
        apply(mk(1,1,0, 1, P,1,0,1,0,0,0));
        apply(mk(1,0,0, 9, P,1,0,1,0,0,0));
        apply(mk(1,0,0, 1, R,0,0,1,0,0,0));
        apply(mk(1,0,0, 8, S,0,1,1,0,0,0));
        apply(mk(1,0,0,12, C,0,1,1,1,0,0));
        apply(mk(1,0,0, 2, C,0,1,1,0,0,0));
        apply(mk(1,1,1, 1, P,1,0,1,0,0,0));
        apply(mk(1,0,0, 9, P,1,0,1,0,0,0));
        apply(mk(1,0,0, 1, R,0,0,1,0,0,0));
        apply(mk(1,0,0, 8, S,0,1,1,0,0,0));
        apply(mk(1,0,0,12, C,0,1,1,1,0,0));

        phase = "timeout";
`ifdef CAM_CFG_TIMEOUT_EN
        apply(mk(1,0,0,49, C,0,1,1,0,0,0));
        apply(mk(1,0,0, 1, P,1,0,1,0,0,1));
        apply(mk(1,0,0,10, R,0,0,1,0,0,1));
        apply(mk(1,0,0, 8, S,0,1,1,0,0,1));
        apply(mk(1,0,0,12, C,0,1,1,1,0,1));
        apply(mk(1,0,0,49, C,0,1,1,0,0,1));
        apply(mk(1,0,1, 1, Y,0,1,1,0,1,1));
`else
        apply(mk(1,0,0,60, C,0,1,1,0,0,0));
        apply(mk(1,0,1, 1, Y,0,1,1,0,1,0));
`endif
        rst = 1'b1;
        apply(mk(1,0,0, 1, W,1,0,0,0,0,0));
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
